branch_resolve_unit: RTL and testbench

Multicycle branch/jump resolution unit for the MP4 RV32I core. It sits downstream of decode and consumes a decoded control-transfer instruction with its operands. It evaluates the branch condition, computes the next PC, the link value and fault flags, and returns the result to the control FSM over a valid/ready handshake. It also keeps resolution statistics counters.

---
 rtl/branch_resolve_unit.sv | 106 ++++++++++
 tb/tb_branch_resolve_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: multicycle branch/jump resolver with valid/ready handshake and saturating stats
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_next_pc,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_link,
  output logic             out_misalign,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  input  logic             clr_stats
);
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
  state_t state;
  logic [1:0] kind;
  logic [2:0] f3;
  logic [XLEN-1:0] rs1, rs2, pc, imm, sum, tgt, lnk;
  logic eq, lts, ltu, cond, ill_c, tk_c, hs;
  assign hs = state == RESP && out_ready;
  // condition, target and link from the latched request
  always_comb begin
    eq    = rs1 == rs2;
    lts   = $signed(rs1) < $signed(rs2);
    ltu   = rs1 < rs2;
    cond  = f3[2] ? ((f3[1] ? ltu : lts) ^ f3[0]) : (eq ^ f3[0]);
    ill_c = kind == 2'd3 || (kind == 2'd0 && f3[2:1] == 2'b01);
    tk_c  = !ill_c && (kind != 2'd0 || cond);
    sum   = (kind == 2'd2 ? rs1 : pc) + imm;
    tgt   = {sum[XLEN-1:1], sum[0] & (kind != 2'd2)};
    lnk   = pc + XLEN'(4);
  end
  // request FSM: latch in IDLE, register results in EVAL, hold in RESP until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_next_pc  <= '0;
      out_link     <= '0;
      out_taken    <= 1'b0;
      out_misalign <= 1'b0;
      out_illegal  <= 1'b0;
      kind         <= '0;
      f3           <= '0;
      rs1          <= '0;
      rs2          <= '0;
      pc           <= '0;
      imm          <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          kind     <= in_kind;
          f3       <= in_funct3;
          rs1      <= in_rs1;
          rs2      <= in_rs2;
          pc       <= in_pc;
          imm      <= in_imm;
          in_ready <= 1'b0;
          state    <= EVAL;
        end
        EVAL: begin
          out_taken    <= tk_c;
          out_illegal  <= ill_c;
          out_link     <= lnk;
          out_next_pc  <= tk_c ? tgt : lnk;
          out_misalign <= tk_c && tgt[1:0] != 2'b00;
          out_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // saturating branch statistics, clear wins over a coincident completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else if (clr_stats) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else if (hs && kind == 2'd0 && !out_illegal) begin
      stat_branches <= stat_branches == '1 ? stat_branches : stat_branches + CNT_W'(1);
      stat_taken    <= (!out_taken || stat_taken == '1) ? stat_taken : stat_taken + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vector table plus handshake, reset, clear and saturation sequences
module tb_branch_resolve_unit;
  localparam int XLEN = 32;
  localparam int CNT_W = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, clr_stats = 1'b0;
  logic [1:0] in_kind = '0;
  logic [2:0] in_funct3 = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0;
  logic [31:0] out_next_pc, out_link;
  logic out_taken, out_misalign, out_illegal;
  logic [CNT_W-1:0] stat_branches, stat_taken;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pc(in_pc), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_next_pc(out_next_pc), .out_taken(out_taken), .out_link(out_link),
    .out_misalign(out_misalign), .out_illegal(out_illegal),
    .stat_branches(stat_branches), .stat_taken(stat_taken), .clr_stats(clr_stats)
  );
  typedef struct {
    logic [1:0] kind; logic [2:0] f3;
    logic [31:0] rs1, rs2, pc, imm, nxt;
    logic tk; logic [31:0] lnk; logic mis, ill;
    logic [3:0] sb, st;
  } vec_t;
  vec_t vt[14];
  function automatic vec_t mk(input logic [1:0] k, input logic [2:0] f,
                              input logic [31:0] a, b, p, i, n, input logic t,
                              input logic [31:0] l, input logic m, il,
                              input logic [3:0] sb, st);
    vec_t v;
    v.kind = k; v.f3 = f; v.rs1 = a; v.rs2 = b; v.pc = p; v.imm = i; v.nxt = n;
    v.tk = t; v.lnk = l; v.mis = m; v.ill = il; v.sb = sb; v.st = st;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic issue(input vec_t v);
    chk("ready_before_issue", in_ready, 1);
    in_kind = v.kind; in_funct3 = v.f3; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_pc = v.pc; in_imm = v.imm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("eval_valid_low", out_valid, 0);
    chk("eval_ready_low", in_ready, 0);
    @(posedge clk); #1;
    chk("resp_valid", out_valid, 1);
  endtask
  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_ready_back", in_ready, 1);
    chk("hs_valid_drop", out_valid, 0);
  endtask
  initial begin
    vt[0]  = mk(0, 0, 32'h5, 32'h5, 32'h100, 32'h20, 32'h120, 1, 32'h104, 0, 0, 1, 1);
    vt[1]  = mk(0, 4, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h10, 32'h210, 1, 32'h204, 0, 0, 2, 2);
    vt[2]  = mk(0, 6, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h10, 32'h204, 0, 32'h204, 0, 0, 3, 2);
    vt[3]  = mk(0, 1, 32'h3, 32'h3, 32'h300, 32'h40, 32'h304, 0, 32'h304, 0, 0, 4, 2);
    vt[4]  = mk(0, 5, 32'h1, 32'hFFFFFFFF, 32'h400, 32'hFFFFFFF8, 32'h3F8, 1, 32'h404, 0, 0, 5, 3);
    vt[5]  = mk(0, 7, 32'h1, 32'hFFFFFFFF, 32'h500, 32'h10, 32'h504, 0, 32'h504, 0, 0, 6, 3);
    vt[6]  = mk(2, 0, 32'h1001, 32'h0, 32'h600, 32'h2, 32'h1002, 1, 32'h604, 1, 0, 6, 3);
    vt[7]  = mk(1, 0, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h8, 32'h4, 1, 32'h0, 0, 0, 6, 3);
    vt[8]  = mk(0, 2, 32'h1, 32'h1, 32'h700, 32'h10, 32'h704, 0, 32'h704, 0, 1, 6, 3);
    vt[9]  = mk(3, 0, 32'h1, 32'h1, 32'h800, 32'h10, 32'h804, 0, 32'h804, 0, 1, 6, 3);
    vt[10] = mk(0, 0, 32'h7, 32'h7, 32'h900, 32'h6, 32'h906, 1, 32'h904, 1, 0, 7, 4);
    vt[11] = mk(0, 1, 32'h2, 32'h2, 32'hA00, 32'h3, 32'hA04, 0, 32'hA04, 0, 0, 8, 4);
    vt[12] = mk(2, 0, 32'h2000, 32'h0, 32'hB00, 32'hFFFFFFFF, 32'h1FFE, 1, 32'hB04, 1, 0, 8, 4);
    vt[13] = mk(0, 6, 32'h1, 32'hFFFFFFFF, 32'hC00, 32'h100, 32'hD00, 1, 32'hC04, 0, 0, 9, 5);
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_next_pc", out_next_pc, 0);
    chk("rst_link", out_link, 0);
    chk("rst_flags", {out_taken, out_misalign, out_illegal}, 0);
    chk("rst_stats", {stat_branches, stat_taken}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      issue(vt[i]);
      chk($sformatf("v%0d_next_pc", i), out_next_pc, vt[i].nxt);
      chk($sformatf("v%0d_taken", i), out_taken, vt[i].tk);
      chk($sformatf("v%0d_link", i), out_link, vt[i].lnk);
      chk($sformatf("v%0d_misalign", i), out_misalign, vt[i].mis);
      chk($sformatf("v%0d_illegal", i), out_illegal, vt[i].ill);
      handshake();
      chk($sformatf("v%0d_stat_br", i), stat_branches, vt[i].sb);
      chk($sformatf("v%0d_stat_tk", i), stat_taken, vt[i].st);
    end
    issue(vt[0]);
    in_valid = 1'b1; in_pc = 32'hDEAD0000; in_kind = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_next_pc", out_next_pc, 32'h120);
      chk("stall_link", out_link, 32'h104);
    end
    in_valid = 1'b0;
    handshake();
    chk("stall_stat_br", stat_branches, 10);
    chk("stall_stat_tk", stat_taken, 6);
    issue(vt[0]);
    clr_stats = 1'b1;
    handshake();
    clr_stats = 1'b0;
    chk("clr_hs_br", stat_branches, 0);
    chk("clr_hs_tk", stat_taken, 0);
    for (int i = 0; i < 17; i++) begin
      issue(vt[0]);
      handshake();
      if (i == 14) chk("sat_reach_br", stat_branches, 15);
    end
    chk("sat_hold_br", stat_branches, 15);
    chk("sat_hold_tk", stat_taken, 15);
    issue(vt[2]);
    handshake();
    chk("sat_nt_br", stat_branches, 15);
    chk("sat_nt_tk", stat_taken, 15);
    in_kind = 2'd0; in_funct3 = 3'd0; in_rs1 = 32'h5; in_rs2 = 32'h5;
    in_pc = 32'h100; in_imm = 32'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_eval_valid", out_valid, 0);
    chk("rst_eval_ready", in_ready, 1);
    chk("rst_eval_stats", {stat_branches, stat_taken}, 0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_drop_valid", out_valid, 0);
      chk("rst_drop_stats", {stat_branches, stat_taken}, 0);
    end
    out_ready = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
